// File: rtl/param_updown_timer.sv
// Up/down timer with synchronised, debounced start/pause and reset buttons,
// tick prescaler and terminal-count done pulse. Define AUTO_RELOAD_EN to wrap instead of stopping.
module param_updown_timer #(
   parameter int WIDTH      = 16,
   parameter int DIV        = 4,
   parameter int DEB_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       btn,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic [1:0]       state
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   logic [1:0] press;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          level_reg;
         logic          level_prev_reg;
         logic [DW-1:0] deb_cnt_reg;

         // level flips on the DEB_CYCLES-th consecutive differing sample
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg      <= 1'b0;
               sync2_reg      <= 1'b0;
               level_reg      <= 1'b0;
               level_prev_reg <= 1'b0;
               deb_cnt_reg    <= '0;
            end else begin
               sync1_reg      <= btn[gi];
               sync2_reg      <= sync1_reg;
               level_prev_reg <= level_reg;
               if (sync2_reg != level_reg) begin
                  if (deb_cnt_reg == DW'(DEB_CYCLES - 1)) begin
                     level_reg   <= sync2_reg;
                     deb_cnt_reg <= '0;
                  end else begin
                     deb_cnt_reg <= deb_cnt_reg + DW'(1);
                  end
               end else begin
                  deb_cnt_reg <= '0;
               end
            end
         end

         assign press[gi] = level_reg & ~level_prev_reg;
      end
   endgenerate

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic             done_reg, done_next;
   logic             run_dir_reg, run_dir_next;
   logic [WIDTH-1:0] limit_reg, limit_next;

   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] idle_load;
   logic             tick;

   assign term      = run_dir_reg ? limit_reg : '0;
   assign reload    = run_dir_reg ? '0 : limit_reg;
   assign idle_load = dir ? '0 : load_val;
   assign tick      = (presc_reg == PW'(DIV - 1));
   // Stepping from the terminal value only happens in auto-reload mode: wrap to the start value
   assign step_val  = (count_reg == term) ? reload
                    : (run_dir_reg ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1));

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      presc_next   = presc_reg;
      done_next    = 1'b0;
      run_dir_next = run_dir_reg;
      limit_next   = limit_reg;

      case (state_reg)
         IDLE: begin
            count_next   = idle_load;
            run_dir_next = dir;
            limit_next   = load_val;
            presc_next   = '0;
            if (press[0]) begin
`ifdef AUTO_RELOAD_EN
               state_next = RUN;
`else
               if (load_val == '0) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next = RUN;
               end
`endif
            end
         end
         RUN: begin
            if (press[0])
               state_next = PAUSE;
            presc_next = tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
               count_next = step_val;
               if (step_val == term) begin
                  done_next = 1'b1;
`ifndef AUTO_RELOAD_EN
                  state_next = DONE;
`endif
               end
            end
         end
         PAUSE: begin
            if (press[0])
               state_next = RUN;
         end
         DONE: begin
            if (press[0]) begin
               state_next = IDLE;
               count_next = idle_load;
               presc_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase

      // reset button overrides anything the start button requested
      if (press[1]) begin
         state_next   = IDLE;
         count_next   = idle_load;
         presc_next   = '0;
         done_next    = 1'b0;
         run_dir_next = dir;
         limit_next   = load_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         presc_reg   <= '0;
         done_reg    <= 1'b0;
         run_dir_reg <= 1'b0;
         limit_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         presc_reg   <= presc_next;
         done_reg    <= done_next;
         run_dir_reg <= run_dir_next;
         limit_reg   <= limit_next;
      end
   end

   assign count   = count_reg;
   assign running = (state_reg == RUN);
   assign done    = done_reg;
   assign state   = state_reg;

endmodule
